// File: rtl/restador_circular.sv
// Registered WIDTH-bit subtractor Y = A - B (mod 2^WIDTH) with Z/N/C/V flags.
// One-cycle latency, one operation per cycle; outputs hold while in_valid is low.
module restador_circular #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             out_valid
);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             z;
        logic             n;
        logic             c;
        logic             v;
    } res_t;

    logic [WIDTH:0] s;
    res_t           res_d;
    res_t           res_q;

    // Top bit of the extended sum is the carry-out: 1 means no borrow.
    assign s = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        res_d   = '0;
        res_d.y = s[WIDTH-1:0];
        res_d.z = (s[WIDTH-1:0] == '0);
        res_d.n = s[WIDTH-1];
        res_d.c = s[WIDTH];
        res_d.v = (A[WIDTH-1] != B[WIDTH-1]) && (s[WIDTH-1] != A[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q     <= '{y: '0, z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                res_q <= res_d;
        end
    end

    assign Y = res_q.y;
    assign Z = res_q.z;
    assign N = res_q.n;
    assign C = res_q.c;
    assign V = res_q.v;

endmodule

// File: tb/tb_restador_circular.sv
// Scoreboard bench for restador_circular at WIDTH=4: directed vectors, hold,
// reset-during-hold and a back-to-back sweep of all 256 operand pairs.
module tb_restador_circular;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Y;
    logic         Z, N, C, V, out_valid;

    int total = 0;
    int bad   = 0;

    // Expected packed as {Y, Z, N, C, V}.
    logic [W+3:0] sb[$];

    restador_circular #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .Y(Y), .Z(Z), .N(N), .C(C), .V(V), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference written from the arithmetic meaning, not the adder form.
    function automatic logic [W+3:0] model(input int a, input int b);
        int    sa, sb_s, d;
        logic [W-1:0] y;
        logic  z, n, c, v;
        y    = W'((a - b) & 15);
        sa   = (a > 7) ? a - 16 : a;
        sb_s = (b > 7) ? b - 16 : b;
        d    = sa - sb_s;
        z    = (y == 0);
        n    = y[W-1];
        c    = (a >= b);
        v    = (d > 7) || (d < -8);
        return {y, z, n, c, v};
    endfunction

    task automatic issue(input int a, input int b, input logic [W+3:0] exp);
        @(posedge clk);
        #1;
        A = W'(a);
        B = W'(b);
        in_valid = 1'b1;
        sb.push_back(exp);
    endtask

    task automatic check(input string name, input logic [W+4:0] got, input logic [W+4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, exp);
        end
    endtask

    // Monitor: every presented result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out got=%b want=<none>", {Y, Z, N, C, V});
            end else begin
                logic [W+3:0] e;
                e = sb.pop_front();
                if ({Y, Z, N, C, V} !== e) begin
                    bad++;
                    $display("FAIL result got=%b want=%b A/B stream", {Y, Z, N, C, V}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with an operation presented: must be discarded.
        A = 4'd5; B = 4'd3; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {Y, Z, N, C, V, out_valid}, {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;

        // Directed vectors, back-to-back, hand-computed {Y,Z,N,C,V}.
        issue(5,  3,  {4'b0010, 1'b0, 1'b0, 1'b1, 1'b0});
        issue(3,  5,  {4'b1110, 1'b0, 1'b1, 1'b0, 1'b0});
        issue(0,  1,  {4'b1111, 1'b0, 1'b1, 1'b0, 1'b0});
        issue(7,  7,  {4'b0000, 1'b1, 1'b0, 1'b1, 1'b0});
        issue(0,  0,  {4'b0000, 1'b1, 1'b0, 1'b1, 1'b0});
        issue(15, 0,  {4'b1111, 1'b0, 1'b1, 1'b1, 1'b0});
        issue(8,  1,  {4'b0111, 1'b0, 1'b0, 1'b1, 1'b1});
        issue(7,  15, {4'b1000, 1'b0, 1'b1, 1'b0, 1'b1});

        // Drop in_valid for 3 cycles: last result holds, out_valid low.
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 4'd2; B = 4'd9;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold_%0d", i), {Y, Z, N, C, V, out_valid},
                  {4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end

        // Reset pulse while holding, with an operation presented.
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; A = 4'd8; B = 4'd1;
        @(posedge clk);
        @(negedge clk);
        check("rst_pulse", {Y, Z, N, C, V, out_valid}, {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        #4;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", {Y, Z, N, C, V, out_valid}, {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        // Exhaustive back-to-back sweep.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                issue(a, b, model(a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drain_outvalid", {5'b0, out_valid}, 6'b0);
        check("sb_empty", (W+5)'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
